// File: rtl/fsr_pkg.sv
// fsr_pkg: shared types and constants for the FIFO stream reader.
// Optional feature macro used by the top level: FSR_UNDERFLOW_CNT_EN.
package fsr_pkg;

   // Burst controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Output skid buffer depth and the width of its occupancy count (0..2).
   localparam int OUT_DEPTH   = 2;
   localparam int OUT_DEPTH_W = 2;

endpackage

// File: rtl/fsr_out_buf.sv
// fsr_out_buf: 2-entry valid/ready output buffer. Words pushed in order are
// presented from the head entry; push and pop may happen in the same cycle
// whenever the buffer holds at least one word.
module fsr_out_buf
   import fsr_pkg::*;
#(
   parameter int DATA_WIDTH = 16
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DATA_WIDTH-1:0]  push_data,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   output logic                   pop,
   output logic [OUT_DEPTH_W-1:0] occ
);

   logic [DATA_WIDTH-1:0]  mem_q [OUT_DEPTH];
   logic [DATA_WIDTH-1:0]  mem_d [OUT_DEPTH];
   logic                   rd_ptr_q, rd_ptr_d;
   logic                   wr_ptr_q, wr_ptr_d;
   logic [OUT_DEPTH_W-1:0] occ_q, occ_d;

   assign out_valid = (occ_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign occ       = occ_q;

   // Next-state for storage, pointers and occupancy from this cycle's push/pop.
   always_comb begin
      pop      = out_valid && out_ready;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      // At full occupancy the write slot is the head being popped; the head is
      // read from the registered copy, so overwriting it on the same edge is safe.
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // Buffer registers; reset empties the buffer and zeroes the presented data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a programmed burst from a FIFO with one-cycle read
// latency and presents it as a valid/ready stream with a last-beat marker.
// Optional macro FSR_UNDERFLOW_CNT_EN adds a saturating starvation-cycle
// counter on port underflow_cnt.
module fifo_stream_reader
   import fsr_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 16
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_read,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic                  busy,
   output logic                  done,
   output logic                  underflow
`ifdef FSR_UNDERFLOW_CNT_EN
   ,
   output logic [LEN_WIDTH-1:0]  underflow_cnt
`endif
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   issued_q, issued_d;
   logic [LEN_WIDTH-1:0]   sent_q, sent_d;
   logic                   inflight_q, inflight_d;
   logic                   underflow_q, underflow_d;
   logic                   done_q, done_d;

   logic                   pop;
   logic [OUT_DEPTH_W-1:0] occ;
   logic                   accept;
   logic                   starve;

   fsr_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data (fifo_dout),
      .out_ready (m_tready),
      .out_data  (m_tdata),
      .out_valid (m_tvalid),
      .pop       (pop),
      .occ       (occ)
   );

   // Read issue and starvation detection. A read is only issued when the word
   // it returns is guaranteed a buffer slot, counting the word already in flight.
   always_comb begin
      accept    = (state_q == IDLE) && start && (burst_len != '0);
      fifo_read = (state_q == RUN) && !fifo_empty && (issued_q < len_q) &&
                  ((int'(occ) + int'(inflight_q) - int'(pop)) < OUT_DEPTH);
      starve    = (state_q == RUN) && (issued_q < len_q) && fifo_empty &&
                  (occ == '0) && !inflight_q;
   end

   // Burst controller next state: counters, in-flight tracking, done and underflow.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      issued_d    = issued_q;
      sent_d      = sent_q;
      underflow_d = underflow_q;
      done_d      = 1'b0;
      inflight_d  = fifo_read;
      if (pop) begin
         sent_d = sent_q + LEN_ONE;
      end
      if (fifo_read) begin
         issued_d = issued_q + LEN_ONE;
      end
      if (starve) begin
         underflow_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = RUN;
               len_d       = burst_len;
               issued_d    = '0;
               sent_d      = '0;
               underflow_d = 1'b0;
            end
         end
         RUN: begin
            if (fifo_read && (issued_q == len_q - LEN_ONE)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // All reads are issued; finish on the edge that empties the buffer.
            if (!inflight_q && ((int'(occ) - int'(pop)) == 0)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         issued_q    <= '0;
         sent_q      <= '0;
         inflight_q  <= 1'b0;
         underflow_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         sent_q      <= sent_d;
         inflight_q  <= inflight_d;
         underflow_q <= underflow_d;
         done_q      <= done_d;
      end
   end

   assign m_tlast   = m_tvalid && (sent_q == len_q - LEN_ONE);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign underflow = underflow_q;

`ifdef FSR_UNDERFLOW_CNT_EN
   logic [LEN_WIDTH-1:0] uf_cnt_q, uf_cnt_d;

   // Saturating count of starved cycles, restarted by each accepted burst.
   always_comb begin
      uf_cnt_d = uf_cnt_q;
      if (accept) begin
         uf_cnt_d = '0;
      end else if (starve && (uf_cnt_q != '1)) begin
         uf_cnt_d = uf_cnt_q + LEN_ONE;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uf_cnt_q <= '0;
      end else begin
         uf_cnt_q <= uf_cnt_d;
      end
   end

   assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized bench with a queue-based FIFO model and an
// expected-word queue; FSR_UNDERFLOW_CNT_EN enables the counter scenario.
module tb_fifo_stream_reader;

   localparam int DW = 16;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_read;
   logic          start = 1'b0;
   logic [LW-1:0] burst_len = '0;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic          m_tlast;
   logic          busy;
   logic          done;
   logic          underflow;
`ifdef FSR_UNDERFLOW_CNT_EN
   logic [LW-1:0] underflow_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int uf_snap = 0;

   // pend: words written by tasks, moved into the FIFO model on the next edge.
   // fq: FIFO model contents. exp_q: words the stream must deliver, in order.
   logic [DW-1:0] pend[$];
   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] fifo_pop_w;

   fifo_stream_reader #(
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_read  (fifo_read),
      .start      (start),
      .burst_len  (burst_len),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .busy       (busy),
      .done       (done),
      .underflow  (underflow)
`ifdef FSR_UNDERFLOW_CNT_EN
      ,
      .underflow_cnt (underflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   // FIFO model: registered read data, empty flag updated on the clock.
   always @(posedge clk) begin
      if (reset) begin
         fq.delete();
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_read && fq.size() > 0) begin
            fifo_pop_w = fq.pop_front();
            fifo_dout <= fifo_pop_w;
         end
         while (pend.size() > 0) fq.push_back(pend.pop_front());
         fifo_empty <= (fq.size() == 0);
      end
   end

   task automatic push_word(input logic [DW-1:0] w);
      pend.push_back(w);
      exp_q.push_back(w);
   endtask

   // Launches a burst and checks every cycle: data/last against exp_q, holds
   // during stalls, legal reads, buffered+in-flight bound, done timing.
   task automatic run_burst(input int len, input int mode, input int inj_cycle,
                            input int inj_n, input int restart_cycle,
                            input bit chk_lat, input string name);
      int cyc = 0, beats = 0, reads = 0, last_hs = 0, first_v = 0, first_hs = 0;
      int limit;
      bit prev_stall = 0, done_exp;
      logic [DW-1:0] prev_data = '0, exp_w;
      logic prev_last = 1'b0, exp_last;
      limit = 40 * len + 100;
      @(negedge clk);
      start = 1'b1;
      burst_len = len[LW-1:0];
      while (cyc < limit && !(last_hs > 0 && cyc >= last_hs + 3)) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_cycle);
         burst_len = (cyc == restart_cycle) ? 16'd1 : len[LW-1:0];
         if (cyc == inj_cycle) begin
            uf_snap = int'(underflow);
            for (int k = 0; k < inj_n; k++) push_word(16'($urandom));
         end
         case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 2 == 1);
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (prev_stall) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
               errors++;
               $display("FAIL %s stall_hold cyc=%0d got v=%b d=%h l=%b need v=1 d=%h l=%b",
                        name, cyc, m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
            end
         end
         if (m_tvalid === 1'b1 && first_v == 0) first_v = cyc;
         checks++;
         if (m_tvalid !== 1'b1 && m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL %s last_without_valid cyc=%0d got %b need 0", name, cyc, m_tlast);
         end
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            checks++;
            if (beats >= len || exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_beat cyc=%0d got beat %0d need at most %0d", name, cyc, beats + 1, len);
            end else begin
               exp_w = exp_q.pop_front();
               exp_last = (beats == len - 1);
               if (m_tdata !== exp_w || m_tlast !== exp_last) begin
                  errors++;
                  $display("FAIL %s beat%0d got d=%h l=%b need d=%h l=%b",
                           name, beats, m_tdata, m_tlast, exp_w, exp_last);
               end
            end
            if (first_hs == 0) first_hs = cyc;
            beats++;
            if (beats == len) last_hs = cyc;
         end
         if (fifo_read === 1'b1) begin
            reads++;
            checks++;
            if (fifo_empty !== 1'b0 || reads - beats > 3) begin
               errors++;
               $display("FAIL %s read_legal cyc=%0d got empty=%b outstanding=%0d need empty=0 outstanding<=3",
                        name, cyc, fifo_empty, reads - beats);
            end
         end
         done_exp = (last_hs > 0 && cyc == last_hs + 1);
         checks++;
         if (done !== done_exp) begin
            errors++;
            $display("FAIL %s done cyc=%0d got %b need %b", name, cyc, done, done_exp);
         end
         if (last_hs > 0 && cyc == last_hs + 2) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL %s busy_after_done got %b need 0", name, busy);
            end
         end
         if (restart_cycle > 0 && cyc == restart_cycle + 1) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy_on_ignored_start got %b need 1", name, busy);
            end
         end
         prev_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
         prev_data = m_tdata;
         prev_last = m_tlast;
      end
      start = 1'b0;
      checks++;
      if (last_hs == 0) begin
         errors++;
         $display("FAIL %s timeout got beats=%0d need %0d", name, beats, len);
      end
      checks++;
      if (reads != len) begin
         errors++;
         $display("FAIL %s read_count got %0d need %0d", name, reads, len);
      end
      if (chk_lat) begin
         checks++;
         if (first_v != 3 || last_hs - first_hs != len - 1) begin
            errors++;
            $display("FAIL %s latency got first_valid=%0d span=%0d need 3 and %0d",
                     name, first_v, last_hs - first_hs, len - 1);
         end
      end
      $display("burst %s len=%0d beats=%0d reads=%0d cycles=%0d", name, len, beats, reads, cyc);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({fifo_read, m_tvalid, m_tlast, busy, done, underflow} !== 6'b0 || m_tdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rd=%b v=%b l=%b b=%b dn=%b uf=%b d=%h need all 0",
                  fifo_read, m_tvalid, m_tlast, busy, done, underflow, m_tdata);
      end
`ifdef FSR_UNDERFLOW_CNT_EN
      checks++;
      if (underflow_cnt !== '0) begin
         errors++;
         $display("FAIL reset_ucnt got %0d need 0", underflow_cnt);
      end
`endif
      reset = 1'b0;
      $display("reset released");
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 8; i++) push_word(16'(i));
      repeat (2) @(negedge clk);
      run_burst(8, 0, 0, 0, 0, 1'b1, "basic");
      checks++;
      if (underflow !== 1'b0) begin
         errors++;
         $display("FAIL basic_underflow got %b need 0", underflow);
      end
   endtask

   task automatic test_stall();
      for (int i = 1; i <= 8; i++) push_word(16'(i));
      repeat (2) @(negedge clk);
      run_burst(8, 1, 0, 0, 0, 1'b0, "stall_toggle");
   endtask

   task automatic test_underflow();
      for (int i = 0; i < 3; i++) push_word(16'($urandom));
      repeat (2) @(negedge clk);
      run_burst(5, 0, 12, 2, 0, 1'b0, "underflow");
      checks++;
      if (uf_snap != 1) begin
         errors++;
         $display("FAIL underflow_rise got %0d need 1", uf_snap);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_sticky got %b need 1", underflow);
      end
      push_word(16'($urandom));
      repeat (2) @(negedge clk);
      run_burst(1, 0, 0, 0, 0, 1'b0, "after_underflow");
      checks++;
      if (underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_cleared_by_start got %b need 0", underflow);
      end
   endtask

   task automatic test_ignored_start();
      push_word(16'($urandom));
      push_word(16'($urandom));
      repeat (3) @(negedge clk);
      start = 1'b1;
      burst_len = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         checks++;
         if (busy !== 1'b0 || fifo_read !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_start got busy=%b rd=%b v=%b need 0 0 0", busy, fifo_read, m_tvalid);
         end
      end
      run_burst(4, 0, 14, 2, 10, 1'b0, "busy_start");
      checks++;
      if (uf_snap != 1) begin
         errors++;
         $display("FAIL underflow_kept_over_ignored_start got %0d need 1", uf_snap);
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      logic prev_rd = 1'b0;
      for (int i = 0; i < 6; i++) push_word(16'($urandom));
      repeat (2) @(negedge clk);
      m_tready = 1'b0;
      start = 1'b1;
      burst_len = 16'd6;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (m_tvalid === 1'b1 && prev_rd === 1'b1) found = 1;
         else prev_rd = fifo_read;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_mid_setup got no valid+inflight need both");
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({fifo_read, m_tvalid, m_tlast, busy, done, underflow} !== 6'b0 || m_tdata !== '0) begin
         errors++;
         $display("FAIL reset_mid_async got rd=%b v=%b l=%b b=%b dn=%b uf=%b d=%h need all 0",
                  fifo_read, m_tvalid, m_tlast, busy, done, underflow, m_tdata);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_done got done=%b busy=%b need 0 0", done, busy);
      end
      for (int i = 0; i < 4; i++) push_word(16'($urandom));
      repeat (2) @(negedge clk);
      run_burst(4, 2, 0, 0, 0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      int len, pre;
      for (int it = 0; it < 4; it++) begin
         len = $urandom_range(1, 12);
         pre = $urandom_range(1, len);
         for (int i = 0; i < pre; i++) push_word(16'($urandom));
         repeat (2) @(negedge clk);
         run_burst(len, 2, 20, len - pre, 0, 1'b0, "random");
      end
   endtask

`ifdef FSR_UNDERFLOW_CNT_EN
   task automatic test_underflow_cnt();
      bit seen = 0;
      logic [DW-1:0] w;
      m_tready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      burst_len = 16'd1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 10) push_word(16'hA5A5);
      end
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (m_tvalid === 1'b1 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            checks++;
            if (m_tdata !== w) begin
               errors++;
               $display("FAIL ucnt_beat got %h need %h", m_tdata, w);
            end
         end
         if (done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || underflow_cnt !== 16'd10 || underflow !== 1'b1) begin
         errors++;
         $display("FAIL ucnt_starved got done_seen=%0d cnt=%0d uf=%b need 1 10 1", seen, underflow_cnt, underflow);
      end
      @(negedge clk);
      push_word(16'h5A5A);
      start = 1'b1;
      burst_len = 16'd1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (underflow_cnt !== '0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL ucnt_clear got cnt=%0d uf=%b need 0 0", underflow_cnt, underflow);
      end
      seen = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (m_tvalid === 1'b1 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            checks++;
            if (m_tdata !== w) begin
               errors++;
               $display("FAIL ucnt_beat2 got %h need %h", m_tdata, w);
            end
         end
         if (done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL ucnt_second_burst timeout got no done need done");
      end
      $display("burst ucnt cnt=%0d", underflow_cnt);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_underflow();
      test_ignored_start();
      test_reset_mid();
      test_random();
`ifdef FSR_UNDERFLOW_CNT_EN
      test_underflow_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
